// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue stage feeding the ALU through a 2-entry registered skid buffer.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_opcode,
  output logic [31:0] out_alu_a,
  output logic [31:0] out_alu_b,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_ls,
  output logic        out_illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        ls;
    logic        illegal;
  } entry_t;
  localparam logic [3:0] OP_ADD = 4'd1;
  state_t state_q, state_d;
  entry_t dec, out_q, out_d, skid_q, skid_d;
  logic [2:0] f3;
  logic [6:0] f7;
  logic alt_r, alt_i, legal, accept, drain;
  logic [31:0] imm_i, imm_s, imm_u;
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign alt_r = f7 == 7'h20;
  assign alt_i = alt_r && f3 == 3'd5;
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u = {in_instr[31:12], 12'b0};
  function automatic logic [3:0] alu_op(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    alu_op = alt ? 4'd2 : 4'd1;
      3'd1:    alu_op = 4'd6;
      3'd2:    alu_op = 4'd9;
      3'd3:    alu_op = 4'd10;
      3'd4:    alu_op = 4'd5;
      3'd5:    alu_op = alt ? 4'd7 : 4'd8;
      3'd6:    alu_op = 4'd4;
      default: alu_op = 4'd3;
    endcase
  endfunction
  always_comb begin
    dec = '0;
    dec.rd = in_instr[11:7];
    legal = 1'b1;
    case (in_instr[6:0])
      7'b0110011: begin
        dec.opcode = alu_op(f3, alt_r);
        dec.a = in_rs1_data;
        dec.b = in_rs2_data;
        dec.wen = 1'b1;
        legal = f7 == 7'h00 || (alt_r && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'b0010011: begin
        dec.opcode = alu_op(f3, alt_i);
        dec.a = in_rs1_data;
        dec.b = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, in_instr[24:20]} : imm_i;
        dec.wen = 1'b1;
        legal = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || alt_r) : 1'b1;
      end
      7'b0110111: begin
        dec.opcode = OP_ADD;
        dec.b = imm_u;
        dec.wen = 1'b1;
      end
      7'b0010111: begin
        dec.opcode = OP_ADD;
        dec.a = in_pc;
        dec.b = imm_u;
        dec.wen = 1'b1;
      end
      7'b0000011: begin
        dec.opcode = OP_ADD;
        dec.a = in_rs1_data;
        dec.b = imm_i;
        dec.ls = 1'b1;
        dec.wen = 1'b1;
      end
      7'b0100011: begin
        dec.opcode = OP_ADD;
        dec.a = in_rs1_data;
        dec.b = imm_s;
        dec.ls = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec = '0;
      dec.rd = in_instr[11:7];
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) dec.wen = 1'b0;
  end
  // ready depends only on the state register, never on out_ready
  assign in_ready = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign accept = in_valid && in_ready;
  assign drain = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) out_d = dec;
        else if (accept) begin
          skid_d = dec;
          state_d = FULL;
        end else if (drain) state_d = EMPTY;
      end
      default: begin
        if (drain) begin
          out_d = skid_q;
          state_d = ONE;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      skid_q <= skid_d;
    end
  end
  assign out_opcode = out_q.opcode;
  assign out_alu_a = out_q.a;
  assign out_alu_b = out_q.b;
  assign out_rd = out_q.rd;
  assign out_wen = out_q.wen;
  assign out_ls = out_q.ls;
  assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed decode, backpressure and reset checks for alu_issue.
module tb_alu_issue;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data, out_alu_a, out_alu_b;
  logic [3:0]  out_opcode;
  logic [4:0]  out_rd;
  logic        out_wen, out_ls, out_illegal;
  int checks = 0;
  int failures = 0;
  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_rd(out_rd), .out_wen(out_wen),
    .out_ls(out_ls), .out_illegal(out_illegal)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic wen, input logic ls,
                         input logic ill);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".op"}, {28'b0, out_opcode}, {28'b0, op});
    chk({tag, ".a"}, out_alu_a, a);
    chk({tag, ".b"}, out_alu_b, b);
    chk({tag, ".rd"}, {27'b0, out_rd}, {27'b0, rd});
    chk({tag, ".flags"}, {29'b0, out_wen, out_ls, out_illegal}, {29'b0, wen, ls, ill});
  endtask
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc = pc;
    in_rs1_data = r1;
    in_rs2_data = r2;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  function automatic logic [31:0] addi(input int k);
    addi = (k << 20) | (k << 7) | 32'h13;
  endfunction
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_instr = '0;
    in_pc = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.ready", {31'b0, in_ready}, 32'd1);
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    issue(32'h002081B3, 0, 5, 7);
    chk_out("add", 1, 1, 5, 7, 3, 1, 0, 0);
    issue(32'h402081B3, 0, 5, 7);
    chk_out("sub", 1, 2, 5, 7, 3, 1, 0, 0);
    issue(32'h40335293, 0, 32'h80000000, 0);
    chk_out("srai", 1, 7, 32'h80000000, 3, 5, 1, 0, 0);
    issue(32'h123450B7, 0, 32'hDEAD, 0);
    chk_out("lui", 1, 1, 0, 32'h12345000, 1, 1, 0, 0);
    issue(32'h12345097, 32'h100, 0, 0);
    chk_out("auipc", 1, 1, 32'h100, 32'h12345000, 1, 1, 0, 0);
    issue(32'hFE20AE23, 0, 32'h1000, 32'h55);
    chk_out("sw", 1, 1, 32'h1000, 32'hFFFFFFFC, 28, 0, 1, 0);
    issue(32'h00812203, 0, 32'h40, 0);
    chk_out("lw", 1, 1, 32'h40, 8, 4, 1, 1, 0);
    issue(32'hFFFFFFFF, 0, 1, 2);
    chk_out("ill_ones", 1, 0, 0, 0, 31, 0, 0, 1);
    issue(32'h022081B3, 0, 5, 7);
    chk_out("ill_f7", 1, 0, 0, 0, 3, 0, 0, 1);
    issue(32'h00508013, 0, 9, 0);
    chk_out("addi_x0", 1, 1, 9, 5, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle.valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    issue(addi(1), 0, 0, 0);
    chk("bp.ready1", {31'b0, in_ready}, 32'd1);
    issue(addi(2), 0, 0, 0);
    chk("bp.ready2", {31'b0, in_ready}, 32'd0);
    chk_out("bp.hold1", 1, 1, 0, 1, 1, 1, 0, 0);
    issue(addi(3), 0, 0, 0);
    in_valid = 1'b1;
    chk("bp.ready3", {31'b0, in_ready}, 32'd0);
    chk_out("bp.hold2", 1, 1, 0, 1, 1, 1, 0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.ready4", {31'b0, in_ready}, 32'd1);
    chk_out("bp.e2", 1, 1, 0, 2, 2, 1, 0, 0);
    @(negedge clk);
    chk_out("bp.e3", 1, 1, 0, 3, 3, 1, 0, 0);
    issue(addi(4), 0, 0, 0);
    chk_out("bp.e4", 1, 1, 0, 4, 4, 1, 0, 0);
    @(negedge clk);
    chk("bp.empty", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    issue(addi(5), 0, 0, 0);
    issue(addi(6), 0, 0, 0);
    chk("full.ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    issue(addi(7), 0, 0, 0);
    rst = 1'b0;
    chk("rst_full.ready", {31'b0, in_ready}, 32'd1);
    chk_out("rst_full", 0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    issue(32'h002081B3, 0, 11, 22);
    chk_out("post_rst", 1, 1, 11, 22, 3, 1, 0, 0);
    @(negedge clk);
    chk("post_rst.drain", {31'b0, out_valid}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
